// File: rtl/sbox_pkg.sv
// Shared types and constants for the word-serial AES S-box.
// Basis matrices map between the AES polynomial basis and the tower-field normal basis
// used by the shared inverter. Each 64-bit constant packs eight 8-bit columns:
// bits [8i+7:8i] hold the image of input bit i.
package sbox_pkg;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;

    localparam logic [7:0]  AffineC     = 8'h63;
    localparam logic [63:0] FwdInBasis  = 64'h98F3F2480981A9FF;  // AES -> normal basis
    localparam logic [63:0] FwdOutBasis = 64'h582D9E0BDC040324;  // normal basis -> affine-mapped AES
    localparam logic [63:0] InvInBasis  = 64'h8C7905EB12045153;  // affine-removed AES -> normal basis
    localparam logic [63:0] InvOutBasis = 64'h64786E8C6829DE60;  // normal basis -> AES

    // GF(2) matrix-vector product: XOR together the columns selected by the set bits of x.
    function automatic logic [7:0] basis_change(input logic [7:0] x, input logic [63:0] m);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) y ^= m[8*i +: 8];
        end
        return y;
    endfunction

endpackage

// File: rtl/sbox_word_serial_if.sv
// Word-level valid/ready bus for the word-serial S-box: one input channel, one output channel.
interface sbox_word_serial_if #(
    parameter int unsigned NBYTES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   D;
    logic                  dec;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   Q;

    modport master (
        output in_valid, D, dec, out_ready,
        input  in_ready, out_valid, Q
    );

    modport slave (
        input  in_valid, D, dec, out_ready,
        output in_ready, out_valid, Q
    );
endinterface

// File: rtl/sbox_bidir.sv
// Bidirectional AES S-box built around a normal-basis GF(2^8) inverter.
// dec_i selects the input/output basis changes, so one inverter serves both directions.
// With PIPE=1 the basis-changed byte and its direction are registered before inversion.
module sbox_bidir
    import sbox_pkg::*;
#(
    parameter int unsigned PIPE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_i,
    input  logic       dec_i,
    output logic [7:0] q_o
);

    // GF(2^2) multiply, normal basis (W^2, W)
    function automatic logic [1:0] g4_mul(input logic [1:0] x, input logic [1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    function automatic logic [1:0] g4_scl_n(input logic [1:0] x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    function automatic logic [1:0] g4_scl_n2(input logic [1:0] x);
        return {x[1] ^ x[0], x[1]};
    endfunction

    // Squaring in a normal basis is a swap; in GF(2^2) it is also the inverse.
    function automatic logic [1:0] g4_sq(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    function automatic logic [3:0] g16_mul(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] e;
        e = g4_scl_n(g4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {g4_mul(x[3:2], y[3:2]) ^ e, g4_mul(x[1:0], y[1:0]) ^ e};
    endfunction

    function automatic logic [3:0] g16_sq_scl(input logic [3:0] x);
        return {g4_sq(x[3:2] ^ x[1:0]), g4_scl_n2(g4_sq(x[1:0]))};
    endfunction

    function automatic logic [3:0] g16_inv(input logic [3:0] x);
        logic [1:0] c, d, e;
        c = g4_scl_n(g4_sq(x[3:2] ^ x[1:0]));
        d = g4_mul(x[3:2], x[1:0]);
        e = g4_sq(c ^ d);
        return {g4_mul(e, x[1:0]), g4_mul(e, x[3:2])};
    endfunction

    function automatic logic [7:0] g256_inv(input logic [7:0] x);
        logic [3:0] c, d, e;
        c = g16_sq_scl(x[7:4] ^ x[3:0]);
        d = g16_mul(x[7:4], x[3:0]);
        e = g16_inv(c ^ d);
        return {g16_mul(e, x[3:0]), g16_mul(e, x[7:4])};
    endfunction

    logic [7:0] nb_d;
    logic [7:0] stage_nb;
    logic       stage_dec;
    logic [7:0] inv_nb;

    // Input basis change; inverse direction strips the affine constant first.
    always_comb begin
        nb_d = dec_i ? basis_change(d_i ^ AffineC, InvInBasis) : basis_change(d_i, FwdInBasis);
    end

    if (PIPE != 0) begin : g_pipe
        logic [7:0] nb_q;
        logic       dec_q;

        // Optional stage after the input basis change; direction travels with the byte.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                nb_q  <= '0;
                dec_q <= 1'b0;
            end else begin
                nb_q  <= nb_d;
                dec_q <= dec_i;
            end
        end

        assign stage_nb  = nb_q;
        assign stage_dec = dec_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign stage_nb       = nb_d;
        assign stage_dec      = dec_i;
    end

    // Field inversion and output basis change; forward direction adds the affine constant.
    always_comb begin
        inv_nb = g256_inv(stage_nb);
        q_o    = stage_dec ? basis_change(inv_nb, InvOutBasis)
                           : (basis_change(inv_nb, FwdOutBasis) ^ AffineC);
    end

endmodule

// File: rtl/sbox_word_serial.sv
// Byte-serial forward/inverse AES S-box for an NBYTES-byte word.
// Latches a word and direction, feeds bytes 0..NBYTES-1 through one shared S-box and
// presents the finished word on a registered Q with a valid/ready handshake.
module sbox_word_serial
    import sbox_pkg::*;
#(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned PIPE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    sbox_word_serial_if.slave    bus
);

    localparam int unsigned     CW   = $clog2(NBYTES) + 1;
    localparam int unsigned     W    = 8 * NBYTES;
    localparam logic [CW-1:0]   Last = CW'(NBYTES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    q_q, q_d;
    logic            dec_q, dec_d;
    logic            out_valid_q, out_valid_d;

    logic            accept;
    logic [7:0]      sb_in, sb_out;
    logic            wr_en;
    logic [CW-1:0]   wr_idx;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.Q         = q_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Select byte cnt of the latched word for the shared S-box.
    always_comb begin
        sb_in = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i)) sb_in = data_q[8*i +: 8];
        end
    end

    sbox_bidir #(
        .PIPE (PIPE)
    ) u_sbox (
        .clk   (clk),
        .rst   (rst),
        .d_i   (sb_in),
        .dec_i (dec_q),
        .q_o   (sb_out)
    );

    if (PIPE != 0) begin : g_wr_pipe
        logic            pv_q, pv_d;
        logic [CW-1:0]   pidx_q, pidx_d;

        // Issue a byte each SUB cycle except the drain cycle, where the last byte is in the stage.
        always_comb begin
            pv_d   = (state_q == SUB) && !(pv_q && (pidx_q == Last));
            pidx_d = cnt_q;
        end

        // Valid tag and byte index that travel alongside the S-box stage register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv_q   <= 1'b0;
                pidx_q <= '0;
            end else begin
                pv_q   <= pv_d;
                pidx_q <= pidx_d;
            end
        end

        assign wr_en  = pv_q;
        assign wr_idx = pidx_q;
    end else begin : g_wr_comb
        assign wr_en  = (state_q == SUB);
        assign wr_idx = cnt_q;
    end

    // Next-state: result byte write, counter, FSM and output register loading.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        dec_d       = dec_q;
        res_d       = res_q;
        q_d         = q_q;
        out_valid_d = out_valid_q;

        for (int i = 0; i < NBYTES; i++) begin
            if (wr_en && (wr_idx == CW'(i))) res_d[8*i +: 8] = sb_out;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SUB;
                    cnt_d   = '0;
                    data_d  = bus.D;
                    dec_d   = bus.dec;
                end
            end
            SUB: begin
                if (cnt_q != Last) cnt_d = cnt_q + 1'b1;
                // Q is loaded only once the whole word is substituted.
                if (wr_en && (wr_idx == Last)) begin
                    state_d     = DONE;
                    q_d         = res_d;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        state_d = SUB;
                        cnt_d   = '0;
                        data_d  = bus.D;
                        dec_d   = bus.dec;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            dec_q       <= 1'b0;
            res_q       <= '0;
            q_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            dec_q       <= dec_d;
            res_q       <= res_d;
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_sbox_word_serial.sv
// Self-checking bench: a 4-byte combinational-S-box instance and a 1-byte pipelined instance,
// each with a scoreboard fed at accept time from an independent GF(2^8) table model.
module tb_sbox_word_serial;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sbox_word_serial_if #(.NBYTES(4)) bus_a ();
    sbox_word_serial_if #(.NBYTES(1)) bus_b ();

    sbox_word_serial #(.NBYTES(4), .PIPE(0)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    sbox_word_serial #(.NBYTES(1), .PIPE(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] model_fwd(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, v);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] d, input logic dv, input int nb);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = dv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        return r;
    endfunction

    // Scoreboards: expected words and accept edges, pushed when a word is taken in.
    logic [31:0] exp_a [$];
    int          acc_a [$];
    logic        ovp_a = 1'b0;
    logic [31:0] exp_b [$];
    int          acc_b [$];
    logic        ovp_b = 1'b0;

    always @(negedge clk) begin
        if (!rst_a) begin
            if (bus_a.out_valid && !ovp_a) begin
                if (acc_a.size() == 0) check("a_spurious_valid", {31'b0, bus_a.out_valid}, 32'h0);
                else check("a_latency", cyc - acc_a.pop_front(), 4);
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (exp_a.size() == 0) check("a_spurious_out", {31'b0, bus_a.out_valid}, 32'h0);
                else check("a_q", bus_a.Q, exp_a.pop_front());
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                exp_a.push_back(model_word(bus_a.D, bus_a.dec, 4));
                acc_a.push_back(cyc + 1);
            end
        end
        ovp_a <= bus_a.out_valid;
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            if (bus_b.out_valid && !ovp_b) begin
                if (acc_b.size() == 0) check("b_spurious_valid", {31'b0, bus_b.out_valid}, 32'h0);
                else check("b_latency", cyc - acc_b.pop_front(), 2);
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                if (exp_b.size() == 0) check("b_spurious_out", {31'b0, bus_b.out_valid}, 32'h0);
                else check("b_q", {24'b0, bus_b.Q}, exp_b.pop_front());
            end
            if (bus_b.in_valid && bus_b.in_ready) begin
                exp_b.push_back(model_word({24'b0, bus_b.D}, bus_b.dec, 1));
                acc_b.push_back(cyc + 1);
            end
        end
        ovp_b <= bus_b.out_valid;
    end

    task automatic send_a(input logic [31:0] d, input logic dv);
        int n;
        n = 0;
        bus_a.in_valid = 1'b1;
        bus_a.D        = d;
        bus_a.dec      = dv;
        @(negedge clk);
        while (!bus_a.in_ready && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (n == 64) check("a_accept_timeout", {31'b0, bus_a.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic dv);
        int n;
        n = 0;
        bus_b.in_valid = 1'b1;
        bus_b.D        = d;
        bus_b.dec      = dv;
        @(negedge clk);
        while (!bus_b.in_ready && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (n == 64) check("b_accept_timeout", {31'b0, bus_b.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus_b.in_valid = 1'b0;
    endtask

    // Ends on a falling edge with out_valid high (or a recorded timeout).
    task automatic wait_out_a();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_a.out_valid && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (n == 64) check("a_out_timeout", {31'b0, bus_a.out_valid}, 32'h1);
    endtask

    task automatic wait_out_b();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_b.out_valid && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (n == 64) check("b_out_timeout", {31'b0, bus_b.out_valid}, 32'h1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("drain_pending", exp_a.size() + exp_b.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hold;
        #500000;
        $display("FAIL watchdog cyc %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hold;
        for (int v = 0; v < 256; v++) begin
            fwd_t[v] = model_fwd(8'(v));
            inv_t[fwd_t[v]] = 8'(v);
        end

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.D = '0; bus_a.dec = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.D = '0; bus_b.dec = 1'b0; bus_b.out_ready = 1'b1;
        #1;
        check("rst_a_ov", {31'b0, bus_a.out_valid}, 32'h0);
        check("rst_a_q", bus_a.Q, 32'h0);
        check("rst_b_ov", {31'b0, bus_b.out_valid}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check("rst_a_in_ready", {31'b0, bus_a.in_ready}, 32'h1);
        check("rst_b_in_ready", {31'b0, bus_b.in_ready}, 32'h1);

        // Forward single word
        send_a(32'h30201000, 1'b0);
        wait_out_a();
        check("t1_q", bus_a.Q, 32'h04B7CA63);
        drain();

        // Inverse round trip and spot bytes
        send_a(32'h04B7CA63, 1'b1);
        wait_out_a();
        check("t2_q", bus_a.Q, 32'h30201000);
        drain();
        send_a(32'h000063ED, 1'b1);
        wait_out_a();
        hold = bus_a.Q;
        check("t2_inv_ed", {24'b0, hold[7:0]}, 32'h53);
        check("t2_inv_63", {24'b0, hold[15:8]}, 32'h00);
        drain();

        // Back-pressure, then take and accept on the same edge
        bus_a.out_ready = 1'b0;
        send_a(32'h00112233, 1'b0);
        wait_out_a();
        hold = bus_a.Q;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_q_stable", bus_a.Q, hold);
            check("t3_ov_held", {31'b0, bus_a.out_valid}, 32'h1);
            check("t3_in_ready_low", {31'b0, bus_a.in_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.D         = 32'hDEADBEEF;
        bus_a.dec       = 1'b0;
        @(negedge clk);
        check("t3_in_ready_no_bubble", {31'b0, bus_a.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        check("t3_ov_cleared", {31'b0, bus_a.out_valid}, 32'h0);
        check("t3_busy", {31'b0, bus_a.in_ready}, 32'h0);
        drain();

        // Inputs ignored during SUB
        send_a(32'hA5C37E01, 1'b1);
        for (int i = 0; i < 2; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.D        = $urandom;
            bus_a.dec      = ~bus_a.dec;
            @(negedge clk);
            check("t6_in_ready_low", {31'b0, bus_a.in_ready}, 32'h0);
            @(posedge clk);
            #1;
        end
        bus_a.in_valid = 1'b0;
        drain();

        // Back-to-back burst with mixed directions
        for (int i = 0; i < 6; i++) send_a($urandom, 1'($urandom_range(0, 1)));
        drain();

        // Reset mid-operation at cnt=2
        send_a(32'h11223344, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        #1;
        check("t4_ov_async", {31'b0, bus_a.out_valid}, 32'h0);
        check("t4_q_async", bus_a.Q, 32'h0);
        exp_a.delete();
        acc_a.delete();
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        check("t4_in_ready_release", {31'b0, bus_a.in_ready}, 32'h1);
        send_a(32'h53535353, 1'b0);
        wait_out_a();
        check("t4_q", bus_a.Q, 32'hEDEDEDED);
        drain();

        // PIPE=1, NBYTES=1
        send_b(8'h53, 1'b0);
        wait_out_b();
        check("t5_q", {24'b0, bus_b.Q}, 32'hED);
        drain();
        for (int v = 0; v < 256; v++) begin
            for (int dv = 0; dv < 2; dv++) send_b(8'(v), dv[0]);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
